// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-stage types and constants
// Contents: NOP_INSTR encoding, fetch_state_t FSM states, if_id_t IF/ID record.
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR = 32'hD503201F;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{pc: 64'd0, instr: NOP_INSTR, valid: 1'b0};

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with hold and bubble insert
// Ports:
//   clk      in   clock
//   rst      in   async active-high reset, clears to bubble
//   i_bubble in   load a bubble (wins over i_hold)
//   i_hold   in   keep current contents
//   i_d      in   fetched record to capture
//   o_q      out  current IF/ID contents
module if_id_reg
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_bubble,
  input  logic   i_hold,
  input  if_id_t i_d,
  output if_id_t o_q
);

  if_id_t r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= IF_ID_BUBBLE;
    end else if (i_bubble) begin
      r_q <= IF_ID_BUBBLE;
    end else if (!i_hold) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - LEGv8 instruction fetch: PC, redirect, stall, halt
// Ports:
//   clk, reset        clock; async active-high reset
//   imem_addr         byte address to ROM (current PC)
//   imem_instr        combinational ROM word
//   stall             hold PC and IF/ID
//   branch_taken      redirect to branch_target and squash IF/ID
//   branch_target     redirect address
//   if_id_pc/instr/valid  IF/ID register contents
//   halted            fetch stopped
//   fault             sticky misaligned-branch halt cause
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 1024,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic [63:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        halted,
  output logic        fault
);

  // pc + 3 >= MEM_SIZE rewritten as pc > MEM_SIZE - 4 so the test cannot wrap.
  localparam logic [63:0] LP_LAST_PC = 64'(MEM_SIZE) - 64'd4;

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  logic [63:0]  r_pc;
  logic [63:0]  w_pc_next;
  logic         r_fault;
  logic         w_fault_next;
  logic         w_bubble;
  logic         w_hold;
  if_id_t       w_capture;
  if_id_t       w_if_id;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
      r_pc    <= RESET_PC;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_fault <= w_fault_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_fault_next = r_fault;
    w_bubble     = 1'b0;
    w_hold       = 1'b0;
    case (r_state)
      RUN: begin
        if (branch_taken) begin
          w_bubble = 1'b1;
          if (branch_target[1:0] != 2'b00) begin
            w_fault_next = 1'b1;
            w_state_next = HALT;
          end else begin
            w_pc_next = branch_target;
          end
        end else if (stall) begin
          w_hold = 1'b1;
        end else if (r_pc > LP_LAST_PC) begin
          w_bubble     = 1'b1;
          w_state_next = HALT;
        end else begin
          w_pc_next = r_pc + 64'd4;
        end
      end
      default: begin
        // IF/ID already holds the bubble loaded on entry to HALT.
        w_hold = 1'b1;
      end
    endcase
  end

  assign w_capture = '{pc: r_pc, instr: imem_instr, valid: 1'b1};

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst     (reset),
    .i_bubble(w_bubble),
    .i_hold  (w_hold),
    .i_d     (w_capture),
    .o_q     (w_if_id)
  );

  assign imem_addr   = r_pc;
  assign if_id_pc    = w_if_id.pc;
  assign if_id_instr = w_if_id.instr;
  assign if_id_valid = w_if_id.valid;
  assign halted      = (r_state == HALT);
  assign fault       = r_fault;

endmodule
